// File: rtl/change_dispense_ctrl_pkg.sv
// Shared types and constants for the change dispense controller.
package vend_pkg;

    // Controller sequencing states; the coin decision is a transition, not a state.
    typedef enum logic [2:0] {
        IDLE,
        PROD,
        PROD_GAP,
        COIN,
        COIN_GAP,
        DONE
    } disp_state_t;

    // Change owed, counted in 5 rs coins (same encoding as the vending FSM).
    localparam logic [1:0] CHG_0  = 2'b00;
    localparam logic [1:0] CHG_5  = 2'b01;
    localparam logic [1:0] CHG_10 = 2'b10;
    localparam logic [1:0] CHG_15 = 2'b11;

    localparam int COIN_VALUE_RS = 5;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Request, actuator and inventory signals between the vending FSM side and the controller.
interface change_dispense_ctrl_if #(
    parameter int INV_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_vend;
    logic [1:0]       req_change;
    logic             prod_eject;
    logic             coin_eject;
    logic             done;
    logic             short;
    logic [1:0]       shortfall;
    logic             refill_en;
    logic [INV_W-1:0] refill_cnt;
    logic [INV_W-1:0] inv_count;
    logic             inv_low;
    logic             inv_empty;

    // Requester / refill side.
    modport master (
        output req_valid, req_vend, req_change, refill_en, refill_cnt,
        input  req_ready, prod_eject, coin_eject, done, short, shortfall,
               inv_count, inv_low, inv_empty
    );

    // Controller side.
    modport slave (
        input  req_valid, req_vend, req_change, refill_en, refill_cnt,
        output req_ready, prod_eject, coin_eject, done, short, shortfall,
               inv_count, inv_low, inv_empty
    );
endinterface

// File: rtl/change_dispense_ctrl_eject.sv
// Shared pulse/gap timer: loads on start, counts down, flags the last cycle of the phase.
module eject_timer
    import vend_pkg::*;
#(
    parameter int EJECT_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic gap_sel,
    output logic expired
);
    localparam int TW = $clog2(max2(EJECT_CYCLES, GAP_CYCLES) + 1);

    logic [TW-1:0] cnt_q;

    // Load the phase length minus one so expired marks the final cycle of the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (start)
            cnt_q <= gap_sel ? TW'(GAP_CYCLES - 1) : TW'(EJECT_CYCLES - 1);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - TW'(1);
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// Sequences product and coin ejector pulses for one dispense request and
// tracks the 5 rs coin inventory, reporting any change it could not pay.
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int EJECT_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int INV_W        = 8,
    parameter int INV_INIT     = 20,
    parameter int LOW_THRESH   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    change_dispense_ctrl_if.slave   bus
);
    disp_state_t      state_q, state_d;
    logic [1:0]       coins_q, coins_d;
    logic             tmr_start, tmr_gap, tmr_expired;
    logic             coin_chk, inv_dec;
    logic             short_d;
    logic [1:0]       shortfall_d;

    logic [INV_W-1:0] inv_q, inv_nxt, add;
    logic [INV_W:0]   sum;

    logic             prod_q, coin_q, done_q, ready_q, short_q;
    logic [1:0]       shortfall_q;

    eject_timer #(
        .EJECT_CYCLES (EJECT_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (tmr_start),
        .gap_sel (tmr_gap),
        .expired (tmr_expired)
    );

    // State and remaining-coin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            coins_q <= CHG_0;
        end else begin
            state_q <= state_d;
            coins_q <= coins_d;
        end
    end

    // Next-state logic; the coin decision is shared by request accept and both gap exits.
    always_comb begin
        state_d     = state_q;
        coins_d     = coins_q;
        tmr_start   = 1'b0;
        tmr_gap     = 1'b0;
        coin_chk    = 1'b0;
        inv_dec     = 1'b0;
        short_d     = 1'b0;
        shortfall_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    coins_d = bus.req_change;
                    if (bus.req_vend) begin
                        state_d   = PROD;
                        tmr_start = 1'b1;
                    end else begin
                        coin_chk  = 1'b1;
                    end
                end
            end
            PROD: begin
                if (tmr_expired) begin
                    state_d   = PROD_GAP;
                    tmr_start = 1'b1;
                    tmr_gap   = 1'b1;
                end
            end
            PROD_GAP: begin
                if (tmr_expired)
                    coin_chk = 1'b1;
            end
            COIN: begin
                if (tmr_expired) begin
                    state_d   = COIN_GAP;
                    tmr_start = 1'b1;
                    tmr_gap   = 1'b1;
                    coins_d   = coins_q - 2'd1;
                end
            end
            COIN_GAP: begin
                if (tmr_expired)
                    coin_chk = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Inventory is read from the register, so a refill that already landed is seen here.
        if (coin_chk) begin
            if (coins_d == CHG_0) begin
                state_d = DONE;
            end else if (inv_q == '0) begin
                state_d     = DONE;
                short_d     = 1'b1;
                shortfall_d = coins_d;
            end else begin
                state_d   = COIN;
                tmr_start = 1'b1;
                inv_dec   = 1'b1;
            end
        end
    end

    // Net inventory update with one spare bit to catch overflow before saturating.
    always_comb begin
        add     = bus.refill_en ? bus.refill_cnt : '0;
        sum     = {1'b0, inv_q} + {1'b0, add} - (INV_W+1)'(inv_dec);
        inv_nxt = sum[INV_W] ? '1 : sum[INV_W-1:0];
    end

    // Inventory register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_q <= INV_W'(INV_INIT);
        else
            inv_q <= inv_nxt;
    end

    // Outputs registered from the next state; reset drops the ejector drives immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= 1'b0;
            coin_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            short_q     <= 1'b0;
            shortfall_q <= 2'b00;
        end else begin
            prod_q      <= (state_d == PROD);
            coin_q      <= (state_d == COIN);
            done_q      <= (state_d == DONE);
            ready_q     <= (state_d == IDLE);
            short_q     <= short_d;
            shortfall_q <= shortfall_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.prod_eject = prod_q;
    assign bus.coin_eject = coin_q;
    assign bus.done       = done_q;
    assign bus.short      = short_q;
    assign bus.shortfall  = shortfall_q;
    assign bus.inv_count  = inv_q;
    assign bus.inv_low    = (inv_q <= INV_W'(LOW_THRESH));
    assign bus.inv_empty  = (inv_q == '0);

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench: each accepted request pushes its expected outcome, popped on done.
module tb_change_dispense_ctrl;
    localparam int E = 4;
    localparam int G = 2;
    localparam int P = E + G;
    localparam int INIT = 20;

    typedef struct {
        int          done_cyc;
        logic        short_f;
        logic [1:0]  shortfall;
        logic [63:0] prod_tr;
        logic [63:0] coin_tr;
        logic [7:0]  inv1;
        logic [7:0]  inv_done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   inv_m  = INIT;
    exp_t sb[$];

    change_dispense_ctrl_if #(.INV_W(8)) bus();

    change_dispense_ctrl #(
        .EJECT_CYCLES (E),
        .GAP_CYCLES   (G),
        .INV_W        (8),
        .INV_INIT     (INIT),
        .LOW_THRESH   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int sat(input int x);
        return (x > 255) ? 255 : ((x < 0) ? 0 : x);
    endfunction

    // Drive a request (optionally with a refill) at a negedge, push its expectation, accept on the edge.
    task automatic drive_accept(input logic v, input logic [1:0] c, input logic hold,
                                input logic hv, input logic [1:0] hc, input int r);
        exp_t e;
        int   n;
        bus.req_valid  = 1'b1;
        bus.req_vend   = v;
        bus.req_change = c;
        bus.refill_en  = (r > 0);
        bus.refill_cnt = 8'(r);
        chk("ready_pre", 64'(bus.req_ready), 64'd1);
        n = (int'(c) < inv_m) ? int'(c) : inv_m;
        e.done_cyc  = 1 + (int'(v) + n) * P;
        e.short_f   = (n < int'(c));
        e.shortfall = 2'(int'(c) - n);
        e.inv1      = 8'(sat(inv_m + r - ((!v && n > 0) ? 1 : 0)));
        e.inv_done  = 8'(sat(inv_m + r - n));
        e.prod_tr   = '0;
        e.coin_tr   = '0;
        for (int cc = 1; cc < e.done_cyc; cc++) begin
            int k;
            int off;
            k   = (cc - 1) / P;
            off = (cc - 1) % P;
            if (off < E && k < int'(v) + n) begin
                if (v && k == 0) e.prod_tr[cc] = 1'b1;
                else             e.coin_tr[cc] = 1'b1;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        inv_m         = int'(e.inv_done);
        bus.refill_en = 1'b0;
        if (hold) begin
            bus.req_vend   = hv;
            bus.req_change = hc;
        end else begin
            bus.req_valid = 1'b0;
        end
    endtask

    // Follow the active request cycle by cycle until done, then compare against the popped entry.
    task automatic track();
        exp_t        e;
        int          cyc = 0;
        int          ready_hi = 0;
        int          overlap = 0;
        logic [63:0] ptr = '0;
        logic [63:0] ctr = '0;
        logic [7:0]  inv1 = '0;
        bit          got = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            ptr[cyc] = bus.prod_eject;
            ctr[cyc] = bus.coin_eject;
            if (bus.prod_eject && bus.coin_eject) overlap++;
            if (bus.req_ready) ready_hi++;
            if (cyc == 1) inv1 = bus.inv_count;
            if (bus.done) got = 1;
        end
        if (!got) begin
            chk("done_timeout", 64'(cyc), 64'(sb.size() ? sb[0].done_cyc : 0));
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk("done_cyc",   64'(cyc),           64'(e.done_cyc));
        chk("short",      64'(bus.short),     64'(e.short_f));
        chk("shortfall",  64'(bus.shortfall), 64'(e.shortfall));
        chk("prod_trace", ptr,                e.prod_tr);
        chk("coin_trace", ctr,                e.coin_tr);
        chk("inv_c1",     64'(inv1),          64'(e.inv1));
        chk("inv_done",   64'(bus.inv_count), 64'(e.inv_done));
        chk("ready_busy", 64'(ready_hi),      64'd0);
        chk("overlap",    64'(overlap),       64'd0);
        @(negedge clk);
        chk("ready_after", 64'(bus.req_ready), 64'd1);
        chk("done_after",  64'(bus.done),      64'd0);
    endtask

    task automatic refill(input int r);
        bus.refill_en  = 1'b1;
        bus.refill_cnt = 8'(r);
        @(posedge clk);
        #1;
        bus.refill_en = 1'b0;
        inv_m = sat(inv_m + r);
        @(negedge clk);
        chk("inv_refill", 64'(bus.inv_count), 64'(inv_m));
    endtask

    initial begin
        int seen_done;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_vend   = 1'b0;
        bus.req_change = 2'b00;
        bus.refill_en  = 1'b0;
        bus.refill_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_inv",   64'(bus.inv_count),  64'(INIT));
        chk("rst_ready", 64'(bus.req_ready),  64'd1);
        chk("rst_prod",  64'(bus.prod_eject), 64'd0);
        chk("rst_coin",  64'(bus.coin_eject), 64'd0);
        chk("rst_done",  64'(bus.done),       64'd0);
        chk("rst_short", 64'({bus.short, bus.shortfall}), 64'd0);
        chk("rst_flags", 64'({bus.inv_low, bus.inv_empty}), 64'd0);

        // Product plus 10 rs change.
        drive_accept(1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 0);
        track();
        // Empty request.
        drive_accept(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0);
        track();
        // Request held valid with new values while busy; the second is taken only after done.
        drive_accept(1'b0, 2'b11, 1'b1, 1'b1, 2'b01, 0);
        track();
        drive_accept(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 0);
        track();
        // Drain to 3 coins.
        repeat (3) begin
            drive_accept(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 0);
            track();
        end
        drive_accept(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 0);
        track();
        chk("low_at3", 64'(bus.inv_low), 64'd1);
        // Refill on the same edge as a coin-entry decrement.
        drive_accept(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 5);
        track();
        // Down to one coin, then a 15 rs request that can only pay one coin.
        repeat (2) begin
            drive_accept(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 0);
            track();
        end
        drive_accept(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 0);
        track();
        chk("empty_flag", 64'(bus.inv_empty), 64'd1);
        // Refill then saturate.
        refill(10);
        refill(255);
        chk("low_full", 64'(bus.inv_low), 64'd0);

        // Reset in the middle of a coin pulse.
        drive_accept(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 0);
        repeat (3) @(negedge clk);
        chk("coin_c3", 64'(bus.coin_eject), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("coin_async", 64'(bus.coin_eject), 64'd0);
        sb.delete();
        inv_m = INIT;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_inv",   64'(bus.inv_count), 64'(inv_m));
        chk("rst2_ready", 64'(bus.req_ready), 64'd1);
        seen_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.coin_eject) seen_done++;
        end
        chk("rst2_quiet", 64'(seen_done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
